// File: rtl/gift_pkg.sv
// Shared definitions for the GiftDec arbiter slice.
//   GIFT_BLK_W / GIFT_KEY_W : block and key widths of the GiftDec core.
//   gift_state_e            : arbiter sequencing states.
package gift_pkg;
  localparam int GIFT_BLK_W = 128;
  localparam int GIFT_KEY_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    KEY_ISSUE,
    KEY_SETTLE,
    KEY_WAIT,
    DATA_ISSUE,
    DATA_SETTLE,
    DATA_WAIT,
    RESP
  } gift_state_e;
endpackage

// File: rtl/gift_dec_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the GiftDec core.
//   inReqValid/outReqReady/inReqKey/inReqData : per-requester request channel
//   outRespValid/inRespReady/outRespData/outRespId : response channel
//   outCoreKeyWr/KeyData/DataWr/DataData, inCoreData/inCoreBusy : core pins
//   outErr : sticky watchdog error, outBusy : arbiter not idle
// slave modport is the arbiter view, master is the environment view.
interface gift_dec_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  import gift_pkg::*;

  logic [NUM_REQ-1:0]            inReqValid;
  logic [NUM_REQ-1:0]            outReqReady;
  logic [NUM_REQ*GIFT_KEY_W-1:0] inReqKey;
  logic [NUM_REQ*GIFT_BLK_W-1:0] inReqData;
  logic                          outRespValid;
  logic                          inRespReady;
  logic [GIFT_BLK_W-1:0]         outRespData;
  logic [ID_W-1:0]               outRespId;
  logic                          outCoreKeyWr;
  logic [GIFT_KEY_W-1:0]         outCoreKeyData;
  logic                          outCoreDataWr;
  logic [GIFT_BLK_W-1:0]         outCoreDataData;
  logic [GIFT_BLK_W-1:0]         inCoreData;
  logic                          inCoreBusy;
  logic                          outErr;
  logic                          outBusy;

  modport slave (
    input  inReqValid, inReqKey, inReqData, inRespReady, inCoreData, inCoreBusy,
    output outReqReady, outRespValid, outRespData, outRespId, outCoreKeyWr,
           outCoreKeyData, outCoreDataWr, outCoreDataData, outErr, outBusy
  );

  modport master (
    output inReqValid, inReqKey, inReqData, inRespReady, inCoreData, inCoreBusy,
    input  outReqReady, outRespValid, outRespData, outRespId, outCoreKeyWr,
           outCoreKeyData, outCoreDataWr, outCoreDataData, outErr, outBusy
  );
endinterface

// File: rtl/gift_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, ptr : highest-priority index
//   gnt : one-hot grant (zero when no request), idx : grant index
module gift_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W:0]   sum;
  logic [W-1:0] j;
  logic         found;

  // Scan ptr, ptr+1, ... with wrap; the first requester seen wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      j = sum[W-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/gift_dec_arbiter.sv
// Round-robin front end sharing one GiftDec core between NUM_REQ requesters.
// Sequences key load (skipped on a key-cache hit) and data load, returns the
// plaintext tagged with the requester ID, and drops a request whose core wait
// exceeds MAX_WAIT cycles (sticky outErr).
//   inClk, inRst : clock, synchronous active-high reset
//   bus          : request/response/core bundle (slave view)
module gift_dec_arbiter
  import gift_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = 1,
  parameter int MAX_WAIT = 255
) (
  input logic              inClk,
  input logic              inRst,
  gift_dec_arbiter_if.slave bus
);
  gift_state_e state_q, state_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, rid_q, rid_d;
  logic [GIFT_KEY_W-1:0] key_q, key_d, ckey_q, ckey_d, sel_key;
  logic [GIFT_BLK_W-1:0] data_q, data_d, resp_q, resp_d, sel_data;
  logic                  cvld_q, cvld_d, err_q, err_d;
  logic [7:0]            wd_q, wd_d;
  logic                  key_wr, data_wr;

  gift_rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req (bus.inReqValid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign sel_key  = bus.inReqKey[int'(gnt_idx)*GIFT_KEY_W +: GIFT_KEY_W];
  assign sel_data = bus.inReqData[int'(gnt_idx)*GIFT_BLK_W +: GIFT_BLK_W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rid_d   = rid_q;
    key_d   = key_q;
    data_d  = data_q;
    ckey_d  = ckey_q;
    cvld_d  = cvld_q;
    resp_d  = resp_q;
    err_d   = err_q;
    wd_d    = wd_q;
    key_wr  = 1'b0;
    data_wr = 1'b0;
    unique case (state_q)
      IDLE: if (|gnt) begin
        key_d  = sel_key;
        data_d = sel_data;
        id_d   = gnt_idx;
        ptr_d  = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + ID_W'(1);
        state_d = (cvld_q && ckey_q == sel_key) ? DATA_ISSUE : KEY_ISSUE;
      end
      KEY_ISSUE: begin
        key_wr  = 1'b1;
        ckey_d  = key_q;
        cvld_d  = 1'b1;
        state_d = KEY_SETTLE;
      end
      KEY_SETTLE: begin
        wd_d    = '0;
        state_d = KEY_WAIT;
      end
      DATA_ISSUE: begin
        data_wr = 1'b1;
        state_d = DATA_SETTLE;
      end
      DATA_SETTLE: begin
        wd_d    = '0;
        state_d = DATA_WAIT;
      end
      KEY_WAIT, DATA_WAIT: begin
        if (!bus.inCoreBusy) begin
          if (state_q == DATA_WAIT) begin
            resp_d  = bus.inCoreData;
            rid_d   = id_q;
            state_d = RESP;
          end else begin
            state_d = DATA_ISSUE;
          end
        end else if (wd_q == 8'(MAX_WAIT-1)) begin
          // Core state is unknown after a hang, so force a key reload next time.
          err_d   = 1'b1;
          cvld_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      RESP: if (bus.inRespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cached key value is only meaningful alongside cvld_q, so it is not reset.
  always_ff @(posedge inClk) begin
    ckey_q <= ckey_d;
    if (inRst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rid_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
      cvld_q  <= 1'b0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      key_q   <= key_d;
      data_q  <= data_d;
      cvld_q  <= cvld_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.outReqReady     = (state_q == IDLE) ? gnt : '0;
  assign bus.outRespValid    = (state_q == RESP);
  assign bus.outRespData     = resp_q;
  assign bus.outRespId       = rid_q;
  assign bus.outCoreKeyWr    = key_wr;
  assign bus.outCoreKeyData  = key_q;
  assign bus.outCoreDataWr   = data_wr;
  assign bus.outCoreDataData = data_q;
  assign bus.outErr          = err_q;
  assign bus.outBusy         = (state_q != IDLE);
endmodule
